// File: rtl/input_capture_mc.sv
// Multi-channel input capture: sync, edge detect, count, timestamp, vld/ack/ovr.
// Ports: i_sysclk/i_sysrst, i_cnt_en, i_clr, i_cap_pin[CH], i_edge_sel[2*CH],
//        i_ack[CH] in; o_ic_flg, o_cap_vld, o_ovr [CH], o_cap_ts, o_cnt_data, o_tb out.
// Optional macro IC_FILTER_EN inserts a FLT_LEN-cycle glitch filter after s1.
module input_capture_mc #(
    parameter int CH      = 4,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 16,
    parameter int FLT_LEN = 3
) (
    input  logic                  i_sysclk,
    input  logic                  i_sysrst,
    input  logic                  i_cnt_en,
    input  logic                  i_clr,
    input  logic [CH-1:0]         i_cap_pin,
    input  logic [2*CH-1:0]       i_edge_sel,
    input  logic [CH-1:0]         i_ack,
    output logic [CH-1:0]         o_ic_flg,
    output logic [CH-1:0]         o_cap_vld,
    output logic [CH-1:0]         o_ovr,
    output logic [CH*TS_W-1:0]    o_cap_ts,
    output logic [CH*CNT_W-1:0]   o_cnt_data,
    output logic [TS_W-1:0]       o_tb
);

    logic [CH-1:0]            s0_q, s1_q, h_q, lvl;
    logic [CH-1:0]            qual;
    logic [CH-1:0]            flg_q, flg_d;
    logic [CH-1:0]            vld_q, vld_d;
    logic [CH-1:0]            ovr_q, ovr_d;
    logic [CH-1:0][TS_W-1:0]  ts_q, ts_d;
    logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]          tb_q, tb_d;

`ifdef IC_FILTER_EN
    localparam logic [3:0] FLT_CMP = 4'(FLT_LEN);

    logic [CH-1:0]      flt_q, flt_d;
    logic [CH-1:0][3:0] fcnt_q, fcnt_d;

    // fcnt counts consecutive s1 samples that disagree with the
    // filtered level; the level flips on the FLT_LEN-th such sample.
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = fcnt_q;
        for (int n = 0; n < CH; n++) begin
            if (s1_q[n] == flt_q[n]) begin
                fcnt_d[n] = '0;
            end else if (fcnt_q[n] + 4'd1 == FLT_CMP) begin
                flt_d[n]  = s1_q[n];
                fcnt_d[n] = '0;
            end else begin
                fcnt_d[n] = fcnt_q[n] + 4'd1;
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            flt_q  <= '0;
            fcnt_q <= '0;
        end else begin
            flt_q  <= flt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = s1_q;
`endif

    // History tracks the level even while disabled, so re-enable
    // never sees a stale edge.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            s0_q <= '0;
            s1_q <= '0;
            h_q  <= '0;
        end else begin
            s0_q <= i_cap_pin;
            s1_q <= s0_q;
            h_q  <= lvl;
        end
    end

    always_comb begin
        qual = '0;
        for (int n = 0; n < CH; n++) begin
            qual[n] = i_cnt_en &
                      ((i_edge_sel[2*n]   &  lvl[n] & ~h_q[n]) |
                       (i_edge_sel[2*n+1] & ~lvl[n] &  h_q[n]));
        end
    end

    always_comb begin
        tb_d  = tb_q;
        cnt_d = cnt_q;
        ts_d  = ts_q;
        vld_d = vld_q;
        ovr_d = ovr_q;
        flg_d = '0;
        if (i_clr) begin
            tb_d  = '0;
            cnt_d = '0;
            vld_d = '0;
            ovr_d = '0;
        end else begin
            if (i_cnt_en) begin
                tb_d = tb_q + TS_W'(1);
            end
            flg_d = qual;
            for (int n = 0; n < CH; n++) begin
                if (qual[n]) begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    ts_d[n]  = tb_q;
                    vld_d[n] = 1'b1;
                    // Ack in the capture cycle consumes the old sample.
                    ovr_d[n] = i_ack[n] ? 1'b0 : (vld_q[n] | ovr_q[n]);
                end else if (i_ack[n]) begin
                    vld_d[n] = 1'b0;
                    ovr_d[n] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            tb_q  <= '0;
            cnt_q <= '0;
            ts_q  <= '0;
            vld_q <= '0;
            ovr_q <= '0;
            flg_q <= '0;
        end else begin
            tb_q  <= tb_d;
            cnt_q <= cnt_d;
            ts_q  <= ts_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
            flg_q <= flg_d;
        end
    end

    assign o_ic_flg   = flg_q;
    assign o_cap_vld  = vld_q;
    assign o_ovr      = ovr_q;
    assign o_cap_ts   = ts_q;
    assign o_cnt_data = cnt_q;
    assign o_tb       = tb_q;

endmodule
